ddr3_dll_lock_ctrl: RTL and testbench

//  Control and monitor stage in front of the DDR3 DLL PF_CCC wrapper. Runs the DLL power-up

---
 rtl/ddr3_dll_lock_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ddr3_dll_lock_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dll_lock_ctrl.sv
// ddr3_dll_lock_ctrl
//   Control/monitor stage in front of the DDR3 DLL wrapper. It powers up the DLL and
//   waits for a filtered lock. It then pulses CODE_UPDATE periodically, or on a DELAY_DIFF
//   rising edge, and republishes the settled 8-bit delay code as a qualified value.
//   Lock loss and lock timeout are detected and retried automatically.
//   Optional feature macro: DDR3_DLL_DRIFT_CHECK_EN rejects code steps larger than
//   DRIFT_THRESH after the first code of each lock; without it every sample is accepted
//   and drift_err is tied low.
module ddr3_dll_lock_ctrl #(
    parameter int PWRUP_WAIT    = 16,
    parameter int LOCK_FILTER   = 8,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int UPDATE_PERIOD = 1024,
    parameter int CODE_SETTLE   = 4
`ifdef DDR3_DLL_DRIFT_CHECK_EN
    ,
    parameter int DRIFT_THRESH  = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dll_lock,
    input  logic       dll_delay_diff,
    input  logic [7:0] dll_code,
    output logic       dll_powerdown_n,
    output logic       dll_code_update,
    output logic [7:0] code_out,
    output logic       code_valid,
    output logic       ready,
    output logic       timeout_err,
    output logic       drift_err,
    output logic [7:0] relock_cnt
);

    // One shared 16-bit width for all cycle counters; terminal values are precomputed
    // as "last count" so each compare is a plain equality.
    localparam int CW = 16;
    localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_WAIT - 1);
    localparam logic [CW-1:0] FILT_LAST    = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] PERIOD_LAST  = CW'(UPDATE_PERIOD - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(CODE_SETTLE - 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_PWRDN,
        S_WAIT_LOCK,
        S_FAULT,
        S_UPDATE,
        S_SAMPLE,
        S_TRACK
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;     // power-up wait / lock timeout / settle
    logic [CW-1:0] filt_reg, filt_next;   // consecutive synced-lock cycles
    logic [CW-1:0] per_reg, per_next;     // cycles since last CODE_UPDATE pulse

    logic          lock_meta_reg, lock_s_reg;
    logic          ddiff_meta_reg, ddiff_s_reg, ddiff_d_reg;

    logic          powerdown_n_reg, code_update_reg;
    logic [7:0]    code_out_reg, code_out_next;
    logic          code_valid_reg, code_valid_next;
    logic          ready_reg, ready_next;
    logic          timeout_err_reg, timeout_err_next;
    logic [7:0]    relock_reg, relock_next;

    logic          lock_lost;
    logic          ddiff_rise;
    logic          sample_take;
    logic          sample_reject;

    assign lock_lost  = !lock_s_reg &&
                        (state_reg == S_UPDATE || state_reg == S_SAMPLE || state_reg == S_TRACK);
    assign ddiff_rise = ddiff_s_reg && !ddiff_d_reg;

    // Two-flop synchronisers for the asynchronous DLL status lines, plus a delay flop
    // on DELAY_DIFF for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_reg  <= 1'b0;
            lock_s_reg     <= 1'b0;
            ddiff_meta_reg <= 1'b0;
            ddiff_s_reg    <= 1'b0;
            ddiff_d_reg    <= 1'b0;
        end else begin
            lock_meta_reg  <= dll_lock;
            lock_s_reg     <= lock_meta_reg;
            ddiff_meta_reg <= dll_delay_diff;
            ddiff_s_reg    <= ddiff_meta_reg;
            ddiff_d_reg    <= ddiff_s_reg;
        end
    end

    // Next-state and next-output logic; overrides applied last in priority order
    // (lock loss, then ENABLE=0 which wins over everything).
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        filt_next        = filt_reg;
        per_next         = (per_reg == CNT_MAX) ? per_reg : per_reg + 1'b1;
        code_out_next    = code_out_reg;
        code_valid_next  = 1'b0;
        ready_next       = ready_reg;
        timeout_err_next = timeout_err_reg;
        relock_next      = relock_reg;
        sample_take      = 1'b0;

        case (state_reg)
            S_PWRDN: begin
                if (cnt_reg == PWRUP_LAST) begin
                    state_next = S_WAIT_LOCK;
                    cnt_next   = '0;
                    filt_next  = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                cnt_next  = cnt_reg + 1'b1;
                filt_next = lock_s_reg ? filt_reg + 1'b1 : '0;
                // A lock completing on the timeout cycle still counts as a lock.
                if (lock_s_reg && filt_reg == FILT_LAST) begin
                    state_next = S_UPDATE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next       = S_FAULT;
                    cnt_next         = '0;
                    timeout_err_next = 1'b1;
                end
            end
            S_FAULT: begin
                state_next = S_PWRDN;
                cnt_next   = '0;
            end
            S_UPDATE: begin
                state_next = S_SAMPLE;
                cnt_next   = '0;
                per_next   = CW'(1);
            end
            S_SAMPLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next  = S_TRACK;
                    cnt_next    = '0;
                    sample_take = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_TRACK: begin
                if (ddiff_rise || per_reg == PERIOD_LAST) begin
                    state_next = S_UPDATE;
                end
            end
            default: begin
                state_next = S_PWRDN;
                cnt_next   = '0;
            end
        endcase

        if (lock_lost) begin
            state_next  = S_WAIT_LOCK;
            cnt_next    = '0;
            filt_next   = '0;
            ready_next  = 1'b0;
            relock_next = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 1'b1;
            sample_take = 1'b0;
        end

        if (!enable) begin
            state_next       = S_PWRDN;
            cnt_next         = '0;
            filt_next        = '0;
            ready_next       = 1'b0;
            relock_next      = relock_reg;
            timeout_err_next = timeout_err_reg;
            sample_take      = 1'b0;
        end

        if (sample_take && !sample_reject) begin
            code_out_next   = dll_code;
            code_valid_next = 1'b1;
            ready_next      = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_PWRDN;
            cnt_reg         <= '0;
            filt_reg        <= '0;
            per_reg         <= '0;
            powerdown_n_reg <= 1'b0;
            code_update_reg <= 1'b0;
            code_out_reg    <= 8'h00;
            code_valid_reg  <= 1'b0;
            ready_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
            relock_reg      <= 8'h00;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            filt_reg        <= filt_next;
            per_reg         <= per_next;
            powerdown_n_reg <= (state_next != S_PWRDN);
            code_update_reg <= (state_next == S_UPDATE);
            code_out_reg    <= code_out_next;
            code_valid_reg  <= code_valid_next;
            ready_reg       <= ready_next;
            timeout_err_reg <= timeout_err_next;
            relock_reg      <= relock_next;
        end
    end

`ifdef DDR3_DLL_DRIFT_CHECK_EN
    localparam logic [8:0] DRIFT_LIMIT = 9'(DRIFT_THRESH);

    logic       first_reg, first_next;
    logic       drift_err_reg, drift_err_next;
    logic [8:0] code_step;

    // Absolute step between the new sample and the published code, and the
    // "first code after lock" qualifier that bypasses the drift check.
    always_comb begin
        code_step = (dll_code >= code_out_reg) ? ({1'b0, dll_code} - {1'b0, code_out_reg})
                                               : ({1'b0, code_out_reg} - {1'b0, dll_code});
        first_next = first_reg;
        if (state_reg == S_WAIT_LOCK && state_next == S_UPDATE) begin
            first_next = 1'b1;
        end else if (sample_take) begin
            first_next = 1'b0;
        end
        drift_err_next = drift_err_reg | (sample_take & sample_reject);
    end

    assign sample_reject = !first_reg && (code_step > DRIFT_LIMIT);

    // Drift bookkeeping registers; drift_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_reg     <= 1'b0;
            drift_err_reg <= 1'b0;
        end else begin
            first_reg     <= first_next;
            drift_err_reg <= drift_err_next;
        end
    end

    assign drift_err = drift_err_reg;
`else
    assign sample_reject = 1'b0;
    assign drift_err     = 1'b0;
`endif

    assign dll_powerdown_n = powerdown_n_reg;
    assign dll_code_update = code_update_reg;
    assign code_out        = code_out_reg;
    assign code_valid      = code_valid_reg;
    assign ready           = ready_reg;
    assign timeout_err     = timeout_err_reg;
    assign relock_cnt      = relock_reg;

endmodule

// File: tb/tb_ddr3_dll_lock_ctrl.sv
// tb_ddr3_dll_lock_ctrl
//   Directed bench for ddr3_dll_lock_ctrl with hand-computed cycle counts and codes.
//   Honours DDR3_DLL_DRIFT_CHECK_EN for the drift-related expectations.
module tb_ddr3_dll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       dll_lock;
    logic       dll_delay_diff;
    logic [7:0] dll_code;
    logic       dll_powerdown_n;
    logic       dll_code_update;
    logic [7:0] code_out;
    logic       code_valid;
    logic       ready;
    logic       timeout_err;
    logic       drift_err;
    logic [7:0] relock_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ddr3_dll_lock_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .dll_lock        (dll_lock),
        .dll_delay_diff  (dll_delay_diff),
        .dll_code        (dll_code),
        .dll_powerdown_n (dll_powerdown_n),
        .dll_code_update (dll_code_update),
        .code_out        (code_out),
        .code_valid      (code_valid),
        .ready           (ready),
        .timeout_err     (timeout_err),
        .drift_err       (drift_err),
        .relock_cnt      (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raise DELAY_DIFF with a new code; report edges to the pulse and pulse-to-valid edges.
    task automatic ddiff_update(input logic [7:0] code, output int upd_lat, output int val_lat);
        dll_code       = code;
        dll_delay_diff = 1'b1;
        upd_lat = -1;
        val_lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dll_code_update) begin
                upd_lat = i;
                break;
            end
        end
        if (upd_lat > 0) begin
            for (int i = 1; i <= 8; i++) begin
                step();
                if (code_valid && val_lat < 0) val_lat = i;
            end
        end
        dll_delay_diff = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_upd;
        int ul;
        int vl;
        int pulses;
        int valids;

        rst_n          = 1'b0;
        enable         = 1'b1;
        dll_lock       = 1'b1;
        dll_delay_diff = 1'b0;
        dll_code       = 8'h3A;
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state
        check_val("rst_powerdown_n", dll_powerdown_n, 0);
        check_val("rst_code_update", dll_code_update, 0);
        check_val("rst_code_out", code_out, 8'h00);
        check_val("rst_ready", ready, 0);
        check_val("rst_relock_cnt", relock_cnt, 0);

        // ---- test 1: power-up, lock filter, first code
        rst_n = 1'b1;
        cyc = 0;
        n = 0;
        while (!dll_powerdown_n && n < 100) begin step(); n++; end
        check_val("pwrup_wait_cycles", n, 16);
        while (!dll_code_update && n < 200) begin step(); n++; end
        check_val("first_update_cycle", n, 24);
        t_upd = cyc;
        step();
        check_val("update_pulse_width", dll_code_update, 0);
        n = 1;
        while (!code_valid && n < 20) begin step(); n++; end
        check_val("settle_latency", n, 5);
        check_val("first_code_out", code_out, 8'h3A);
        check_val("first_ready", ready, 1);
        step();
        check_val("code_valid_width", code_valid, 0);

        // ---- test 2: periodic update spacing, then DELAY_DIFF triggered update
        dll_code = 8'h3C;
        n = 0;
        while (!dll_code_update && n < 1100) begin step(); n++; end
        check_val("update_period", cyc - t_upd, 1024);
        n = 0;
        while (!code_valid && n < 20) begin step(); n++; end
        check_val("periodic_code_out", code_out, 8'h3C);
        repeat (4) step();
        ddiff_update(8'h40, ul, vl);
        check_val("ddiff_update_latency", ul, 3);
        check_val("ddiff_valid_latency", vl, 5);
        check_val("ddiff_code_out", code_out, 8'h40);

        // ---- test 5: drift option
        ddiff_update(8'h50, ul, vl);
`ifdef DDR3_DLL_DRIFT_CHECK_EN
        check_val("drift_reject_valid", vl, 32'hFFFF_FFFF);
        check_val("drift_reject_code", code_out, 8'h40);
        check_val("drift_err_set", drift_err, 1);
        check_val("drift_ready_kept", ready, 1);
`else
        check_val("nodrift_valid", vl, 5);
        check_val("nodrift_code", code_out, 8'h50);
        check_val("nodrift_err", drift_err, 0);
`endif
        ddiff_update(8'h47, ul, vl);
        check_val("small_step_valid", vl, 5);
        check_val("small_step_code", code_out, 8'h47);

        // ---- test 4: lock loss while READY, then a short glitch in WAIT_LOCK
        dll_lock = 1'b0;
        n = 0;
        while (ready && n < 20) begin step(); n++; end
        check_val("lock_loss_ready_latency", n, 3);
        check_val("relock_cnt_one", relock_cnt, 1);
        check_val("lock_loss_code_hold", code_out, 8'h47);
        repeat (4) step();
        dll_lock = 1'b1;
        repeat (5) step();
        dll_lock = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dll_code_update || ready) pulses++;
        end
        check_val("glitch_no_lock", pulses, 0);
        dll_lock = 1'b1;
        n = 0;
        while (!code_valid && n < 100) begin step(); n++; end
        check_val("relock_valid_latency", n, 15);
        check_val("relock_ready", ready, 1);
        check_val("relock_cnt_still_one", relock_cnt, 1);

        // ---- test 6a: ENABLE=0 during SAMPLE
        repeat (4) step();
        dll_code       = 8'h99;
        dll_delay_diff = 1'b1;
        n = 0;
        while (!dll_code_update && n < 10) begin step(); n++; end
        check_val("pre_disable_update", dll_code_update, 1);
        step();
        enable = 1'b0;
        step();
        check_val("disable_powerdown_n", dll_powerdown_n, 0);
        check_val("disable_ready", ready, 0);
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (code_valid) valids++;
        end
        check_val("disable_no_valid", valids, 0);
        check_val("disable_code_hold", code_out, 8'h47);
        check_val("disable_relock_cnt", relock_cnt, 1);
        dll_delay_diff = 1'b0;
        enable = 1'b1;
        n = 0;
        while (!code_valid && n < 100) begin step(); n++; end
        check_val("reenable_valid_latency", n, 29);
        check_val("reenable_code_out", code_out, 8'h99);

        // ---- test 6b: asynchronous reset pulse while tracking
        repeat (3) step();
        #3;
        rst_n = 1'b0;
        #1;
        check_val("areset_powerdown_n", dll_powerdown_n, 0);
        check_val("areset_code_out", code_out, 8'h00);
        check_val("areset_ready", ready, 0);
        check_val("areset_code_valid", code_valid, 0);
        check_val("areset_relock_cnt", relock_cnt, 0);

        // ---- test 3: lock never arrives -> timeout, retry, later lock
        dll_lock = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!timeout_err && n < 5000) begin step(); n++; end
        check_val("timeout_cycle", n, 4112);
        n = 0;
        while (dll_powerdown_n && n < 10) begin step(); n++; end
        check_val("fault_to_pwrdn", n, 1);
        n = 0;
        while (!dll_powerdown_n && n < 100) begin step(); n++; end
        check_val("retry_pwrdn_cycles", n, 16);
        dll_lock = 1'b1;
        n = 0;
        while (!ready && n < 100) begin step(); n++; end
        check_val("retry_ready", ready, 1);
        check_val("retry_timeout_sticky", timeout_err, 1);
        check_val("retry_code_out", code_out, 8'h99);
        check_val("retry_relock_cnt", relock_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
